softcore_cpu_mult_combine: RTL and testbench



---
 rtl/softcore_cpu_mult_combine_pkg.sv | 20 ++
 rtl/softcore_cpu_pipe_reg.sv | 42 ++++
 rtl/softcore_cpu_mult_combine.sv | 75 +++++++
 tb/tb_softcore_cpu_mult_combine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/softcore_cpu_mult_combine_pkg.sv
// rtl/softcore_cpu_mult_combine_pkg.sv - shared widths and tag type for the multiplier cell
package softcore_cpu_mult_combine_pkg;

    localparam int MUL_PP_W   = 32;
    localparam int MUL_HALF_W = 16;
    localparam int MUL_TAG_W  = 5;

    typedef logic [MUL_TAG_W-1:0] mul_tag_t;

    // Only the low half of the cross-term sum lands inside the 32-bit result.
    function automatic logic [MUL_HALF_W-1:0] mul_mid(
        input logic [MUL_HALF_W-1:0] p2_lo,
        input logic [MUL_HALF_W-1:0] p3_lo
    );
        logic [MUL_HALF_W-1:0] sum;
        sum = p2_lo + p3_lo;
        return sum;
    endfunction

endpackage

// File: rtl/softcore_cpu_pipe_reg.sv
// rtl/softcore_cpu_pipe_reg.sv - valid/ready register slice with flush
module softcore_cpu_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_en;

    assign w_en      = ~r_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_en) begin
                r_valid <= in_valid;
            end
            // Data only moves on a real load, so a stalled slice keeps its payload.
            if (w_en & in_valid & ~flush) begin
                r_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/softcore_cpu_mult_combine.sv
// rtl/softcore_cpu_mult_combine.sv - reduces three 16x16 partials to the low 32 bits of A*B
module softcore_cpu_mult_combine
    import softcore_cpu_mult_combine_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W,
    parameter int PP_W  = MUL_PP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  in_p1,
    input  logic [PP_W-1:0]  in_p2,
    input  logic [PP_W-1:0]  in_p3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PP_W-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int A_W = PP_W + MUL_HALF_W + TAG_W;
    localparam int B_W = PP_W + TAG_W;

    logic                  w_a_in_ready;
    logic                  w_a_valid;
    logic                  w_b_en;
    logic [A_W-1:0]        w_a_din;
    logic [A_W-1:0]        w_a_dout;
    logic [PP_W-1:0]       w_a_p1;
    logic [MUL_HALF_W-1:0] w_a_mid;
    logic [TAG_W-1:0]      w_a_tag;
    logic [B_W-1:0]        w_b_din;
    logic [B_W-1:0]        w_b_dout;
    logic [PP_W-1:0]       w_sum;
    logic                  w_unused;

    assign in_ready = w_a_in_ready & ~flush & ~reset;
    assign w_a_din  = {in_p1, mul_mid(in_p2[MUL_HALF_W-1:0], in_p3[MUL_HALF_W-1:0]), in_tag};
    assign w_unused = ^{in_p2[PP_W-1:MUL_HALF_W], in_p3[PP_W-1:MUL_HALF_W]};

    softcore_cpu_pipe_reg #(.W(A_W)) u_stage_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid & in_ready),
        .in_ready  (w_a_in_ready),
        .in_data   (w_a_din),
        .out_valid (w_a_valid),
        .out_ready (w_b_en),
        .out_data  (w_a_dout)
    );

    assign {w_a_p1, w_a_mid, w_a_tag} = w_a_dout;
    assign w_sum   = w_a_p1 + {w_a_mid, {MUL_HALF_W{1'b0}}};
    assign w_b_din = {w_sum, w_a_tag};

    softcore_cpu_pipe_reg #(.W(B_W)) u_stage_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (w_a_valid),
        .in_ready  (w_b_en),
        .in_data   (w_b_din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_b_dout)
    );

    assign {out_result, out_tag} = w_b_dout;
    assign busy = w_a_valid | out_valid;

endmodule

// File: tb/tb_softcore_cpu_mult_combine.sv
// tb/tb_softcore_cpu_mult_combine.sv - self-checking bench for softcore_cpu_mult_combine
module tb_softcore_cpu_mult_combine;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_p1, in_p2, in_p3, out_result;
    logic [4:0]  in_tag, out_tag;

    int checks = 0;
    int errors = 0;
    int n_emit = 0;

    logic [31:0] q_res[$];
    logic [4:0]  q_tag[$];
    logic [31:0] cur_exp;
    logic [4:0]  cur_tag;
    logic        hold = 1'b0;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;

    always #5 clk = ~clk;

    softcore_cpu_mult_combine dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
    endfunction

    task automatic set_ab(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        logic [31:0] al, ah, bl, bh;
        al = {16'b0, a[15:0]};
        ah = {16'b0, a[31:16]};
        bl = {16'b0, b[15:0]};
        bh = {16'b0, b[31:16]};
        in_valid = v;
        in_p1    = al * bl;
        in_p2    = al * bh;
        in_p3    = ah * bl;
        in_tag   = tag;
        cur_exp  = ref_mul(a, b);
        cur_tag  = tag;
    endtask

    // Sample just before the edge, update the in-order model, then advance to the next negedge.
    task automatic tick();
        bit exp_rdy;
        #1;
        if (reset) begin
            chk("in_ready_in_reset", {63'b0, in_ready}, 64'd0);
            q_res.delete();
            q_tag.delete();
            hold = 1'b0;
        end else begin
            exp_rdy = !flush && (q_res.size() < 2 || out_ready);
            chk("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
            if (hold) begin
                chk("hold_valid", {63'b0, out_valid}, 64'd1);
                chk("hold_result", {32'b0, out_result}, {32'b0, hold_res});
                chk("hold_tag", {59'b0, out_tag}, {59'b0, hold_tag});
            end
            if (out_valid) begin
                if (q_res.size() == 0) begin
                    chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
                end else if (out_ready) begin
                    chk("out_result", {32'b0, out_result}, {32'b0, q_res[0]});
                    chk("out_tag", {59'b0, out_tag}, {59'b0, q_tag[0]});
                    void'(q_res.pop_front());
                    void'(q_tag.pop_front());
                    n_emit++;
                end
            end
            hold     = out_valid && !out_ready && !flush;
            hold_res = out_result;
            hold_tag = out_tag;
            if (flush) begin
                q_res.delete();
                q_tag.delete();
            end else if (in_valid && exp_rdy) begin
                q_res.push_back(cur_exp);
                q_tag.push_back(cur_tag);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_ab(1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_out_result", {32'b0, out_result}, 64'd0);
        chk("rst_out_tag", {59'b0, out_tag}, 64'd0);
        reset = 1'b0;
        #1 chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

        // Basic product with 2-cycle latency
        out_ready = 1'b1;
        set_ab(1'b1, 32'h00030002, 32'h00050004, 5'd3);
        chk("basic_p1", {32'b0, in_p1}, 64'h8);
        tick();
        in_valid = 1'b0;
        chk("basic_lat1", {63'b0, out_valid}, 64'd0);
        tick();
        chk("basic_valid", {63'b0, out_valid}, 64'd1);
        chk("basic_result", {32'b0, out_result}, 64'h00160008);
        chk("basic_tag", {59'b0, out_tag}, 64'd3);
        tick();

        // Wrap-around cases streamed back to back
        set_ab(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        chk("wrap_p1", {32'b0, in_p1}, 64'hFFFE0001);
        tick();
        set_ab(1'b1, 32'h00010000, 32'h00010000, 5'd8);
        tick();
        in_valid = 1'b0;
        chk("wrap_result", {32'b0, out_result}, 64'h1);
        chk("wrap_tag", {59'b0, out_tag}, 64'd7);
        tick();
        chk("zero_result", {32'b0, out_result}, 64'h0);
        chk("zero_tag", {59'b0, out_tag}, 64'd8);
        tick();
        tick();

        // Backpressure: tags 1..4, consumer stalls in cycles 2..6
        begin
            int nt;
            nt = 1; acc = 0; n_emit = 0;
            for (int c = 1; c <= 14; c++) begin
                out_ready = !(c >= 2 && c <= 6);
                if (nt <= 4) set_ab(1'b1, $urandom, $urandom, nt[4:0]);
                else in_valid = 1'b0;
                #1;
                if (in_valid && in_ready) begin
                    nt++;
                    if (c <= 6) acc++;
                end
                tick();
            end
            chk("bp_accepts_while_stalled", acc, 2);
            chk("bp_emitted", n_emit, 4);
        end

        // Flush with two ops in flight plus a same-cycle input
        out_ready = 1'b0;
        set_ab(1'b1, $urandom, $urandom, 5'd10);
        tick();
        set_ab(1'b1, $urandom, $urandom, 5'd11);
        tick();
        set_ab(1'b1, $urandom, $urandom, 5'd12);
        flush = 1'b1;
        #1 chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_busy", {63'b0, busy}, 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        set_ab(1'b1, 32'h00001234, 32'h00005678, 5'd13);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_flush_valid", {63'b0, out_valid}, 64'd1);
        chk("post_flush_result", {32'b0, out_result}, 64'h06260060);
        chk("post_flush_tag", {59'b0, out_tag}, 64'd13);
        tick();

        // Reset with both stages full and consumer stalled
        out_ready = 1'b0;
        set_ab(1'b1, $urandom, $urandom, 5'd14);
        tick();
        set_ab(1'b1, $urandom, $urandom, 5'd15);
        tick();
        in_valid = 1'b0;
        chk("full_busy", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_out_result", {32'b0, out_result}, 64'd0);
        chk("midrst_out_tag", {59'b0, out_tag}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        #1 chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);

        // Random traffic against the in-order model
        for (int i = 0; i < 10000; i++) begin
            set_ab(($urandom % 4) != 0, $urandom, $urandom, 5'($urandom));
            out_ready = ($urandom % 10) < 7;
            flush     = ($urandom % 32) == 0;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && (q_res.size() != 0 || busy); i++) tick();
        chk("drain_model_empty", q_res.size(), 0);
        chk("drain_busy", {63'b0, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
